bin_act_b6: RTL
===============

# bin_act_b6

Block-6 binarisation stage, directly downstream of the block-6 max-pool. It takes the five signed 10-bit pooled values and compares each against a per-channel threshold. This yields a 5-bit activation word (one bit per channel). The word is buffered in a small FIFO and handed to the next convolution stage over a valid/ready handshake. It also counts pooled positions per frame and flags the frame end and any overflow.

## Interface
Parameters:
- `DATA_W`, 10: width of each signed pooled value.
- `FIFO_DEPTH`, 8: activation FIFO depth in words; must be a power of 2 and ≥ 2.
- `FRAME_LEN`, 46: pooled positions per frame.
- `THR_0` … `THR_4`, 0: signed `DATA_W`-bit per-channel reset thresholds.

Ports:
- `clk`, in, 1: clock; one clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `max_0` … `max_4`, in, `DATA_W` signed: pooled values, channels 0–4.
- `max_val`, in, 1: pooled values are valid this cycle; single-cycle pulses, no backpressure upstream.
- `act_data`, out, 5: activation word; bit c belongs to channel c.
- `act_val`, out, 1: `act_data` is valid (FIFO not empty).
- `act_rdy`, in, 1: downstream accepts the word; a transfer happens when `act_val && act_rdy`.
- `frame_done`, out, 1: one-cycle pulse when the last position of a frame is written.
- `ovf`, out, 1: sticky; set when an input word is dropped.
- `level`, out, log2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Compare stage, registered: `bit_c = (max_c >= thr_c)`, as a signed comparison over the full `DATA_W` bits. An equal value gives 1.
  - The register stage holds `cmp_word[4:0]` and `cmp_val`; `cmp_val <= max_val`.
- FIFO write happens when `cmp_val` is high. The write is accepted if the FIFO is not full, or if a read happens in the same cycle (full with simultaneous read means the write succeeds).
  - Otherwise the word is dropped, `ovf` is set, and the position still counts toward the frame.
- FIFO is show-ahead: `act_data` presents the head word whenever `act_val` is high. It holds stable until a transfer completes.
- Read and write in the same cycle, FIFO not empty and not full: `level` is unchanged.
- Read when empty: `act_rdy` is ignored and nothing changes.
- Position counter `pos` runs 0…FRAME_LEN-1 and increments on each `cmp_val`.
  - At `pos == FRAME_LEN-1` it wraps to 0 and `frame_done` pulses in that same cycle.
- `ovf` clears only on reset.
- Reset, including mid-frame: FIFO is emptied, `pos` = 0, the compare register is cleared, and thresholds return to `THR_*`.

## Timing
- Reset values: `act_data` = 0, `act_val` = 0, `frame_done` = 0, `ovf` = 0, `level` = 0.
- Latency with an empty FIFO: `max_val` in cycle t gives `cmp_val` in t+1, the FIFO write in t+1, and `act_val` = 1 with the word in t+2.
- `frame_done` is asserted in cycle t+1 relative to the `max_val` of the last position.
- `level` updates on the edge after the write/read.
- Sustained rate: one word per cycle in and out. The upstream stride-2 pooling gives at most one word every 2 cycles.

## Configuration
- `BIN_THR_LOAD_EN`:
  - Defined: adds ports `thr_wr_en` (in, 1), `thr_wr_sel` (in, 3) and `thr_wr_data` (in, `DATA_W` signed). When `thr_wr_en` is high and `thr_wr_sel` < 5, the selected threshold register is updated on the clock edge. The new value applies from the next compare. A `thr_wr_sel` of 5 or more is ignored.
  - Undefined: thresholds are constants `THR_0`…`THR_4`, and these ports are absent.

## Structure
- Shared package `ecg_b6_pkg`:
  - Constants `B6_CH_NUM` = 5 and `B6_DATA_W` = 10.
  - Typedef `b6_act_t` (5-bit activation word).
- One sub-module, `act_fifo_b6`: a show-ahead synchronous FIFO with parameters `WIDTH` and `DEPTH`, outputs `full`/`empty`/`level`, and asynchronous active-low reset.
- Compare, frame counter, overflow logic and optional threshold registers live in the top module.

## Test plan
- THR = 0, single pulse, inputs `{-1, 0, 1, 511, -512}` → in cycle t+2, `act_data` = 5'b01110 and `act_val` = 1; held while `act_rdy` = 0, gone after one cycle with `act_rdy` = 1.
- `act_rdy` held at 0, 9 input pulses with DEPTH = 8 → `level` = 8, `ovf` = 1, and the 9th word is absent from the drained sequence.
- Full FIFO, `act_rdy` = 1 in the same cycle as the write → the write is accepted, `level` stays 8, and `ovf` stays 0.
- FRAME_LEN = 46, 92 pulses → `frame_done` pulses exactly twice, at the 46th and 92nd positions, each one cycle after the respective `max_val`.
- `rst_n` asserted with `level` = 5 and `pos` = 20 → outputs go to 0 immediately; after release, the next frame ends after 46 positions.
- `BIN_THR_LOAD_EN` defined: write channel 2 threshold = 100, then input 99 / 100 → bit 2 is 0 / 1; a write with `thr_wr_sel` = 6 has no effect.

Source files
------------

// File: rtl/ecg_b6_pkg.sv
// Shared constants and types for the block-6 binarisation stage.
package ecg_b6_pkg;

  localparam int unsigned B6_CH_NUM = 5;
  localparam int unsigned B6_DATA_W = 10;

  // One activation bit per channel; bit c belongs to channel c.
  typedef logic [B6_CH_NUM-1:0] b6_act_t;

  // True when a threshold select addresses an existing channel.
  function automatic logic thr_sel_valid(input logic [2:0] sel);
    return sel < 3'(B6_CH_NUM);
  endfunction

endpackage

// File: rtl/act_fifo_b6.sv
// Show-ahead synchronous FIFO for activation words.
// The head word is presented on rd_data whenever the FIFO is not empty and reads as 0 otherwise.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module act_fifo_b6 #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign level = count_q;

  // Reads on an empty FIFO are ignored; a full FIFO still accepts a write paired with a read.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy next state; simultaneous read and write leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bin_act_b6.sv
// Block-6 binarisation: per-channel signed threshold compare, activation FIFO,
// frame position counter and sticky overflow flag.
// Optional feature macro BIN_THR_LOAD_EN adds runtime-writable threshold registers.
module bin_act_b6
  import ecg_b6_pkg::*;
#(
  parameter int unsigned               DATA_W     = B6_DATA_W,
  parameter int unsigned               FIFO_DEPTH = 8,
  parameter int unsigned               FRAME_LEN  = 46,
  parameter logic signed [DATA_W-1:0]  THR_0      = '0,
  parameter logic signed [DATA_W-1:0]  THR_1      = '0,
  parameter logic signed [DATA_W-1:0]  THR_2      = '0,
  parameter logic signed [DATA_W-1:0]  THR_3      = '0,
  parameter logic signed [DATA_W-1:0]  THR_4      = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_W-1:0]      max_0,
  input  logic signed [DATA_W-1:0]      max_1,
  input  logic signed [DATA_W-1:0]      max_2,
  input  logic signed [DATA_W-1:0]      max_3,
  input  logic signed [DATA_W-1:0]      max_4,
  input  logic                          max_val,
  output logic [B6_CH_NUM-1:0]          act_data,
  output logic                          act_val,
  input  logic                          act_rdy,
  output logic                          frame_done,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef BIN_THR_LOAD_EN
  ,
  input  logic                          thr_wr_en,
  input  logic [2:0]                    thr_wr_sel,
  input  logic signed [DATA_W-1:0]      thr_wr_data
`endif
);

  localparam int unsigned PosW = $clog2(FRAME_LEN + 1);
  localparam logic signed [DATA_W-1:0] ThrInit [B6_CH_NUM] = '{THR_0, THR_1, THR_2, THR_3, THR_4};

  logic signed [DATA_W-1:0] max_a [B6_CH_NUM];
  logic signed [DATA_W-1:0] thr   [B6_CH_NUM];

  b6_act_t         cmp_word_d, cmp_word_q;
  logic            cmp_val_q;
  logic [PosW-1:0] pos_q, pos_d;
  logic            pos_last;
  logic            ovf_q;
  logic            fifo_full, fifo_empty;

  assign max_a[0] = max_0;
  assign max_a[1] = max_1;
  assign max_a[2] = max_2;
  assign max_a[3] = max_3;
  assign max_a[4] = max_4;

`ifdef BIN_THR_LOAD_EN
  logic signed [DATA_W-1:0] thr_q [B6_CH_NUM];

  // Runtime threshold registers; selects beyond the last channel are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < B6_CH_NUM; c++) thr_q[c] <= ThrInit[c];
    end else if (thr_wr_en && thr_sel_valid(thr_wr_sel)) begin
      for (int c = 0; c < B6_CH_NUM; c++) begin
        if (thr_wr_sel == 3'(c)) thr_q[c] <= thr_wr_data;
      end
    end
  end

  assign thr = thr_q;
`else
  assign thr = ThrInit;
`endif

  // Signed compare per channel; equality counts as active.
  always_comb begin
    cmp_word_d = '0;
    for (int c = 0; c < B6_CH_NUM; c++) cmp_word_d[c] = (max_a[c] >= thr[c]);
  end

  // Compare register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_word_q <= '0;
      cmp_val_q  <= 1'b0;
    end else begin
      cmp_word_q <= cmp_word_d;
      cmp_val_q  <= max_val;
    end
  end

  // Position counter advances on every compared word, dropped or not.
  assign pos_last = (pos_q == PosW'(FRAME_LEN - 1));

  always_comb begin
    pos_d = pos_q;
    if (cmp_val_q) pos_d = pos_last ? '0 : pos_q + PosW'(1);
  end

  assign frame_done = cmp_val_q && pos_last;

  // Frame position and sticky overflow (a full FIFO with no read drops the word).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      if (cmp_val_q && fifo_full && !act_rdy) ovf_q <= 1'b1;
    end
  end

  assign ovf     = ovf_q;
  assign act_val = !fifo_empty;

  act_fifo_b6 #(
    .WIDTH (B6_CH_NUM),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cmp_val_q),
    .wr_data (cmp_word_q),
    .rd_en   (act_rdy),
    .rd_data (act_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule
